mem_stage: RTL and testbench

Memory-access stage of the 5-stage CPU, directly upstream of the write-back mux. Accepts one instruction at a time from EX, performs loads/stores against data memory over a valid/ready request + response-valid interface, and presents a registered result bundle (ALU result, aligned/extended load data, control flags) to write-back. Stalls EX via `in_ready` while a memory transaction is outstanding.

---
 rtl/mem_stage_pkg.sv | 61 ++++++
 rtl/mem_stage_load_align.sv | 46 ++++
 rtl/mem_stage.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the memory-access stage.
//   XLEN, funct3 size/sign encodings, FSM state encoding, store strobe width,
//   and helpers that decode access size and effective byte offset.
package mem_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = 4;

    // funct3 load/store size and sign encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // Access size from funct3; unused encodings fall back to word.
    function automatic size_t f3_size(input logic [2:0] f3);
        size_t s;
        case (f3[1:0])
            2'b00:   s = SZ_BYTE;
            2'b01:   s = SZ_HALF;
            default: s = SZ_WORD;
        endcase
        return s;
    endfunction

    // Byte offset actually used: low bits a size cannot address are dropped.
    function automatic logic [1:0] eff_off(input logic [2:0] f3, input logic [1:0] off);
        logic [1:0] o;
        case (f3_size(f3))
            SZ_BYTE: o = off;
            SZ_HALF: o = {off[1], 1'b0};
            default: o = 2'b00;
        endcase
        return o;
    endfunction

    // Natural-alignment violation for half/word accesses.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic m;
        case (f3_size(f3))
            SZ_HALF: m = off[0];
            SZ_WORD: m = (off != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: combinational load data alignment.
//   i_rdata    : word-aligned word returned by data memory
//   i_off      : address bits [1:0] of the access
//   i_funct3   : load size/sign encoding
//   o_data_c   : selected byte/half/word, sign- or zero-extended to XLEN
module load_align #(
    parameter int unsigned XLEN = mem_stage_pkg::XLEN
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_off,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data_c
);
    import mem_stage_pkg::*;

    logic [1:0]  w_off;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_unsigned;

    assign w_off      = eff_off(i_funct3, i_off);
    assign w_unsigned = i_funct3[2];

    // Lane select
    always_comb begin
        w_byte = i_rdata[7:0];
        case (w_off)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = w_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Extension to XLEN
    always_comb begin
        o_data_c = i_rdata;
        case (f3_size(i_funct3))
            SZ_BYTE: o_data_c = {{(XLEN-8){w_byte[7] & ~w_unsigned}}, w_byte};
            SZ_HALF: o_data_c = {{(XLEN-16){w_half[15] & ~w_unsigned}}, w_half};
            default: o_data_c = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX and write-back.
//   Accepts one EX bundle at a time (in_valid/in_ready), issues loads/stores on
//   a valid/ready request channel with a separate response-valid channel, and
//   presents a registered write-back bundle with a one-cycle out_valid pulse.
// Ports:
//   clk, rst_n                        : clock, async active-low reset
//   in_*                              : EX bundle (in_ready high only in IDLE)
//   dmem_req_valid/ready, dmem_we,
//   dmem_addr/wdata/wstrb             : memory request (held stable while waiting)
//   dmem_rsp_valid, dmem_rdata        : load response (honoured only in RESP)
//   out_*                             : write-back bundle, held between completions
// Build option: define MEM_MISALIGN_TRAP_EN to flag misaligned half/word
//   accesses (no memory request, out_misaligned=1, out_regWrite=0); otherwise
//   offending low address bits are ignored and out_misaligned is tied low.
module mem_stage #(
    parameter int unsigned XLEN = mem_stage_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_memRead,
    input  logic            in_is_memWrite,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_alu_data,
    input  logic [XLEN-1:0] in_store_data,
    input  logic [4:0]      in_rd,
    input  logic            in_regWrite,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            out_valid,
    output logic            out_is_memRead,
    output logic            out_is_memWrite,
    output logic [XLEN-1:0] out_alu_data,
    output logic [XLEN-1:0] out_mem_data,
    output logic [4:0]      out_rd,
    output logic            out_regWrite,
    output logic            out_misaligned
);
    import mem_stage_pkg::*;

    state_t              r_state,     w_state_nxt;

    // Captured in-flight instruction
    logic                r_we,        w_we_nxt;
    logic [XLEN-1:0]     r_addr,      w_addr_nxt;
    logic [XLEN-1:0]     r_wdata,     w_wdata_nxt;
    logic [STRB_W-1:0]   r_wstrb,     w_wstrb_nxt;
    logic [2:0]          r_funct3,    w_funct3_nxt;
    logic [4:0]          r_rd,        w_rd_nxt;
    logic                r_regwrite,  w_regwrite_nxt;
    logic                r_is_rd,     w_is_rd_nxt;
    logic                r_is_wr,     w_is_wr_nxt;

    // Write-back bundle
    logic                r_out_valid,    w_out_valid_nxt;
    logic                r_out_is_rd,    w_out_is_rd_nxt;
    logic                r_out_is_wr,    w_out_is_wr_nxt;
    logic [XLEN-1:0]     r_out_alu,      w_out_alu_nxt;
    logic [XLEN-1:0]     r_out_mem,      w_out_mem_nxt;
    logic [4:0]          r_out_rd,       w_out_rd_nxt;
    logic                r_out_regwrite, w_out_regwrite_nxt;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                r_out_mis,      w_out_mis_nxt;
    logic                w_misaligned;
`endif

    logic                w_is_mem;
    logic [1:0]          w_st_off;
    logic [XLEN-1:0]     w_st_wdata;
    logic [STRB_W-1:0]   w_st_wstrb;
    logic [XLEN-1:0]     w_load_data;

    assign w_is_mem = in_is_memRead | in_is_memWrite;

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misaligned = w_is_mem & is_misaligned(in_funct3, in_alu_data[1:0]);
`endif

    // Store lane replication and byte strobes, computed at capture time
    always_comb begin
        w_st_off   = eff_off(in_funct3, in_alu_data[1:0]);
        w_st_wdata = in_store_data;
        w_st_wstrb = 4'b1111;
        case (f3_size(in_funct3))
            SZ_BYTE: begin
                w_st_wdata = XLEN'({4{in_store_data[7:0]}});
                w_st_wstrb = 4'b0001 << w_st_off;
            end
            SZ_HALF: begin
                w_st_wdata = XLEN'({2{in_store_data[15:0]}});
                w_st_wstrb = w_st_off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_st_wdata = in_store_data;
                w_st_wstrb = 4'b1111;
            end
        endcase
    end

    load_align #(
        .XLEN     (XLEN)
    ) u_load_align (
        .i_rdata  (dmem_rdata),
        .i_off    (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_data_c (w_load_data)
    );

    // Next-state and next-register logic
    always_comb begin
        w_state_nxt        = r_state;
        w_we_nxt           = r_we;
        w_addr_nxt         = r_addr;
        w_wdata_nxt        = r_wdata;
        w_wstrb_nxt        = r_wstrb;
        w_funct3_nxt       = r_funct3;
        w_rd_nxt           = r_rd;
        w_regwrite_nxt     = r_regwrite;
        w_is_rd_nxt        = r_is_rd;
        w_is_wr_nxt        = r_is_wr;
        w_out_valid_nxt    = 1'b0;
        w_out_is_rd_nxt    = r_out_is_rd;
        w_out_is_wr_nxt    = r_out_is_wr;
        w_out_alu_nxt      = r_out_alu;
        w_out_mem_nxt      = r_out_mem;
        w_out_rd_nxt       = r_out_rd;
        w_out_regwrite_nxt = r_out_regwrite;
`ifdef MEM_MISALIGN_TRAP_EN
        w_out_mis_nxt      = r_out_mis;
`endif

        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (w_is_mem) begin
`ifdef MEM_MISALIGN_TRAP_EN
                        if (w_misaligned) begin
                            // Flag and retire without touching memory
                            w_out_valid_nxt    = 1'b1;
                            w_out_is_rd_nxt    = in_is_memRead;
                            w_out_is_wr_nxt    = in_is_memWrite;
                            w_out_alu_nxt      = in_alu_data;
                            w_out_mem_nxt      = '0;
                            w_out_rd_nxt       = in_rd;
                            w_out_regwrite_nxt = 1'b0;
                            w_out_mis_nxt      = 1'b1;
                        end else
`endif
                        begin
                            w_we_nxt       = in_is_memWrite;
                            w_addr_nxt     = in_alu_data;
                            w_wdata_nxt    = w_st_wdata;
                            w_wstrb_nxt    = w_st_wstrb;
                            w_funct3_nxt   = in_funct3;
                            w_rd_nxt       = in_rd;
                            w_regwrite_nxt = in_regWrite;
                            w_is_rd_nxt    = in_is_memRead;
                            w_is_wr_nxt    = in_is_memWrite;
                            w_state_nxt    = ST_REQ;
                        end
                    end else begin
                        // Non-memory op passes straight to the output register
                        w_out_valid_nxt    = 1'b1;
                        w_out_is_rd_nxt    = 1'b0;
                        w_out_is_wr_nxt    = 1'b0;
                        w_out_alu_nxt      = in_alu_data;
                        w_out_mem_nxt      = '0;
                        w_out_rd_nxt       = in_rd;
                        w_out_regwrite_nxt = in_regWrite;
`ifdef MEM_MISALIGN_TRAP_EN
                        w_out_mis_nxt      = 1'b0;
`endif
                    end
                end
            end

            ST_REQ: begin
                if (dmem_req_ready) begin
                    if (r_we) begin
                        w_out_valid_nxt    = 1'b1;
                        w_out_is_rd_nxt    = r_is_rd;
                        w_out_is_wr_nxt    = r_is_wr;
                        w_out_alu_nxt      = r_addr;
                        w_out_mem_nxt      = '0;
                        w_out_rd_nxt       = r_rd;
                        w_out_regwrite_nxt = r_regwrite;
`ifdef MEM_MISALIGN_TRAP_EN
                        w_out_mis_nxt      = 1'b0;
`endif
                        w_state_nxt        = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                if (dmem_rsp_valid) begin
                    w_out_valid_nxt    = 1'b1;
                    w_out_is_rd_nxt    = r_is_rd;
                    w_out_is_wr_nxt    = r_is_wr;
                    w_out_alu_nxt      = r_addr;
                    w_out_mem_nxt      = w_load_data;
                    w_out_rd_nxt       = r_rd;
                    w_out_regwrite_nxt = r_regwrite;
`ifdef MEM_MISALIGN_TRAP_EN
                    w_out_mis_nxt      = 1'b0;
`endif
                    w_state_nxt        = ST_IDLE;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_wstrb        <= '0;
            r_funct3       <= '0;
            r_rd           <= '0;
            r_regwrite     <= 1'b0;
            r_is_rd        <= 1'b0;
            r_is_wr        <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_is_rd    <= 1'b0;
            r_out_is_wr    <= 1'b0;
            r_out_alu      <= '0;
            r_out_mem      <= '0;
            r_out_rd       <= '0;
            r_out_regwrite <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_out_mis      <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_we           <= w_we_nxt;
            r_addr         <= w_addr_nxt;
            r_wdata        <= w_wdata_nxt;
            r_wstrb        <= w_wstrb_nxt;
            r_funct3       <= w_funct3_nxt;
            r_rd           <= w_rd_nxt;
            r_regwrite     <= w_regwrite_nxt;
            r_is_rd        <= w_is_rd_nxt;
            r_is_wr        <= w_is_wr_nxt;
            r_out_valid    <= w_out_valid_nxt;
            r_out_is_rd    <= w_out_is_rd_nxt;
            r_out_is_wr    <= w_out_is_wr_nxt;
            r_out_alu      <= w_out_alu_nxt;
            r_out_mem      <= w_out_mem_nxt;
            r_out_rd       <= w_out_rd_nxt;
            r_out_regwrite <= w_out_regwrite_nxt;
`ifdef MEM_MISALIGN_TRAP_EN
            r_out_mis      <= w_out_mis_nxt;
`endif
        end
    end

    // Handshake and request outputs decode directly from registered state
    assign in_ready        = (r_state == ST_IDLE);
    assign dmem_req_valid  = (r_state == ST_REQ);
    assign dmem_we         = r_we;
    assign dmem_addr       = {r_addr[XLEN-1:2], 2'b00};
    assign dmem_wdata      = r_wdata;
    assign dmem_wstrb      = r_wstrb;

    assign out_valid       = r_out_valid;
    assign out_is_memRead  = r_out_is_rd;
    assign out_is_memWrite = r_out_is_wr;
    assign out_alu_data    = r_out_alu;
    assign out_mem_data    = r_out_mem;
    assign out_rd          = r_out_rd;
    assign out_regWrite    = r_out_regwrite;
`ifdef MEM_MISALIGN_TRAP_EN
    assign out_misaligned  = r_out_mis;
`else
    assign out_misaligned  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed + randomized bench for mem_stage with a
// specification-level reference model for load extraction and store lanes.
module tb_mem_stage;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic            in_is_memRead;
    logic            in_is_memWrite;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_alu_data;
    logic [XLEN-1:0] in_store_data;
    logic [4:0]      in_rd;
    logic            in_regWrite;
    logic            dmem_req_valid;
    logic            dmem_req_ready;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_wstrb;
    logic            dmem_rsp_valid;
    logic [XLEN-1:0] dmem_rdata;
    logic            out_valid;
    logic            out_is_memRead;
    logic            out_is_memWrite;
    logic [XLEN-1:0] out_alu_data;
    logic [XLEN-1:0] out_mem_data;
    logic [4:0]      out_rd;
    logic            out_regWrite;
    logic            out_misaligned;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] st_f3 [3] = '{3'b000, 3'b001, 3'b010};

    mem_stage #(.XLEN(XLEN)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_is_memRead   (in_is_memRead),
        .in_is_memWrite  (in_is_memWrite),
        .in_funct3       (in_funct3),
        .in_alu_data     (in_alu_data),
        .in_store_data   (in_store_data),
        .in_rd           (in_rd),
        .in_regWrite     (in_regWrite),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_wstrb      (dmem_wstrb),
        .dmem_rsp_valid  (dmem_rsp_valid),
        .dmem_rdata      (dmem_rdata),
        .out_valid       (out_valid),
        .out_is_memRead  (out_is_memRead),
        .out_is_memWrite (out_is_memWrite),
        .out_alu_data    (out_alu_data),
        .out_mem_data    (out_mem_data),
        .out_rd          (out_rd),
        .out_regWrite    (out_regWrite),
        .out_misaligned  (out_misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte offset the access really uses, from size rules
    function automatic int unsigned ref_off(input logic [2:0] f3, input logic [31:0] addr);
        if (f3[1:0] == 2'b00) return addr % 4;
        if (f3[1:0] == 2'b01) return (addr % 4) & 2;
        return 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [2:0] f3);
        logic [31:0] v;
        v = rdata >> (8 * ref_off(f3, addr));
        case (f3)
            3'b000: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
            3'b100: v = v & 32'hFF;
            3'b001: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
            3'b101: v = v & 32'hFFFF;
            default: v = rdata;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] s, input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return (s & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 2'b01) return (s & 32'hFFFF) * 32'h0001_0001;
        return s;
    endfunction

    function automatic logic [31:0] ref_wstrb(input logic [31:0] addr, input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 32'd1 << ref_off(f3, addr);
        if (f3[1:0] == 2'b01) return 32'd3 << ref_off(f3, addr);
        return 32'hF;
    endfunction

    // One instruction from issue to completion; starts and ends on a falling edge in IDLE
    task automatic do_op(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                         input logic regw, input int req_dly, input int rsp_dly,
                         input logic [31:0] rdata);
        logic        mem;
        logic        trap;
        logic [31:0] exp_mem;
        mem     = rd_op | wr_op;
        trap    = 1'b0;
        exp_mem = 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap = mem & (((f3[1:0] == 2'b10) && (addr % 4 != 0)) ||
                      ((f3[1:0] == 2'b01) && (addr % 2 != 0)));
`endif
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid       = 1'b1;
        in_is_memRead  = rd_op;
        in_is_memWrite = wr_op;
        in_funct3      = f3;
        in_alu_data    = addr;
        in_store_data  = sdata;
        in_rd          = rd;
        in_regWrite    = regw;
        @(negedge clk);
        in_valid      = 1'b0;
        in_alu_data   = $urandom;
        in_store_data = $urandom;
        in_rd         = 5'($urandom);
        if (mem && !trap) begin
            for (int k = 0; k <= req_dly; k++) begin
                chk("req_valid", 32'(dmem_req_valid), 32'd1);
                chk("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
                chk("req_we", 32'(dmem_we), 32'(wr_op));
                chk("in_ready_busy", 32'(in_ready), 32'd0);
                chk("out_valid_req", 32'(out_valid), 32'd0);
                if (wr_op) begin
                    chk("req_wdata", dmem_wdata, ref_wdata(sdata, f3));
                    chk("req_wstrb", 32'(dmem_wstrb), ref_wstrb(addr, f3));
                end
                dmem_req_ready = (k == req_dly);
                dmem_rsp_valid = (k < req_dly) ? 1'($urandom_range(0, 1)) : 1'b0;
                dmem_rdata     = $urandom;
                @(negedge clk);
            end
            dmem_req_ready = 1'b0;
            dmem_rsp_valid = 1'b0;
            if (rd_op) begin
                for (int j = 0; j <= rsp_dly; j++) begin
                    chk("req_valid_resp", 32'(dmem_req_valid), 32'd0);
                    chk("in_ready_resp", 32'(in_ready), 32'd0);
                    chk("out_valid_resp", 32'(out_valid), 32'd0);
                    if (j == rsp_dly) begin
                        dmem_rsp_valid = 1'b1;
                        dmem_rdata     = rdata;
                    end
                    @(negedge clk);
                end
                dmem_rsp_valid = 1'b0;
                dmem_rdata     = $urandom;
                exp_mem        = ref_load(rdata, addr, f3);
            end
        end
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_alu_data", out_alu_data, addr);
        chk("out_mem_data", out_mem_data, trap ? 32'h0 : exp_mem);
        chk("out_rd", 32'(out_rd), 32'(rd));
        chk("out_regWrite", 32'(out_regWrite), trap ? 32'd0 : 32'(regw));
        chk("out_is_memRead", 32'(out_is_memRead), 32'(rd_op));
        chk("out_is_memWrite", 32'(out_is_memWrite), 32'(wr_op));
        chk("out_misaligned", 32'(out_misaligned), 32'(trap));
        chk("in_ready_done", 32'(in_ready), 32'd1);
        chk("req_valid_done", 32'(dmem_req_valid), 32'd0);
        @(negedge clk);
        chk("out_valid_pulse", 32'(out_valid), 32'd0);
        chk("out_alu_hold", out_alu_data, addr);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;
        int          kind;

        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_is_memRead  = 1'b0;
        in_is_memWrite = 1'b0;
        in_funct3      = 3'b000;
        in_alu_data    = '0;
        in_store_data  = '0;
        in_rd          = '0;
        in_regWrite    = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_req_valid", 32'(dmem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_alu", out_alu_data, 32'h0);
        chk("rst_wstrb", 32'(dmem_wstrb), 32'h0);
        chk("rst_misaligned", 32'(out_misaligned), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD result, register write to x5
        do_op(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'hDEAD_BEEF, 5'd5, 1'b1, 0, 0, 32'h0);
        // SB with delayed acceptance
        do_op(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 5'd0, 1'b0, 3, 0, 32'h0);
        // Sub-word loads
        do_op(1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0, 5'd7, 1'b1, 0, 0, 32'h0080_0000);
        do_op(1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0, 5'd8, 1'b1, 0, 0, 32'h0080_0000);
        do_op(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd9, 1'b1, 0, 0, 32'h8001_0000);
        do_op(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 5'd9, 1'b1, 1, 1, 32'h8001_0000);
        // LW with slow response
        do_op(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd10, 1'b1, 0, 5, 32'hCAFE_F00D);
        // Misaligned word load and half store
        do_op(1'b1, 1'b0, 3'b010, 32'h0000_0201, 32'h0, 5'd11, 1'b1, 0, 0, 32'h1234_5678);
        do_op(1'b0, 1'b1, 3'b001, 32'h0000_0303, 32'h0000_BEEF, 5'd0, 1'b0, 0, 0, 32'h0);
        // Minimum-latency SH/SW
        do_op(1'b0, 1'b1, 3'b001, 32'h0000_0402, 32'h1111_A5C3, 5'd0, 1'b0, 0, 0, 32'h0);
        do_op(1'b0, 1'b1, 3'b010, 32'h0000_0404, 32'h8765_4321, 5'd0, 1'b0, 0, 0, 32'h0);

        // Stray response while idle
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        chk("idle_rsp_ignored", 32'(out_valid), 32'd0);
        chk("idle_rsp_ready", 32'(in_ready), 32'd1);

        // Reset while waiting in REQ
        in_valid = 1'b1; in_is_memRead = 1'b0; in_is_memWrite = 1'b1;
        in_funct3 = 3'b010; in_alu_data = 32'h0000_0500; in_rd = 5'd0; in_regWrite = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("req_before_rst", 32'(dmem_req_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_req_drop", 32'(dmem_req_valid), 32'd0);
        chk("rst_req_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while waiting in RESP, then a late response
        in_valid = 1'b1; in_is_memRead = 1'b1; in_is_memWrite = 1'b0;
        in_funct3 = 3'b010; in_alu_data = 32'h0000_0600; in_rd = 5'd3; in_regWrite = 1'b1;
        @(negedge clk);
        in_valid       = 1'b0;
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        chk("resp_before_rst", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_resp_req_valid", 32'(dmem_req_valid), 32'd0);
        chk("rst_resp_out_valid", 32'(out_valid), 32'd0);
        chk("rst_resp_in_ready", 32'(in_ready), 32'd1);
        chk("rst_resp_out_alu", out_alu_data, 32'h0);
        chk("rst_resp_out_rd", 32'(out_rd), 32'd0);
        @(negedge clk);
        rst_n          = 1'b1;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h5555_AAAA;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        chk("late_rsp_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("late_rsp_out_valid2", 32'(out_valid), 32'd0);
        chk("late_rsp_in_ready", 32'(in_ready), 32'd1);

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 2));
            a    = $urandom;
            d    = $urandom;
            if (kind == 0) begin
                do_op(1'b0, 1'b0, 3'($urandom), a, d, 5'($urandom), 1'($urandom), 0, 0, 32'h0);
            end else if (kind == 1) begin
                f = ld_f3[$urandom_range(0, 4)];
                do_op(1'b1, 1'b0, f, a, 32'h0, 5'($urandom), 1'b1,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), d);
            end else begin
                f = st_f3[$urandom_range(0, 2)];
                do_op(1'b0, 1'b1, f, a, d, 5'($urandom), 1'b0,
                      int'($urandom_range(0, 3)), 0, 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
